// File: rtl/uart_command_sequencer.sv
// Decodes multi-byte UART command frames into register-file and ALU operations
// and serialises the responses (read byte, ALU result bytes or error code) to the UART transmitter.
module uart_command_sequencer #(
    parameter int unsigned DATA_WIDTH          = 8,
    parameter int unsigned REGISTER_FILE_DEPTH = 16,
    parameter int unsigned ALU_RESULT_WIDTH    = 16,
    parameter int unsigned TIMEOUT_CYCLES      = 1024,
    parameter logic [7:0]  ERROR_CODE          = 8'hEE
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   receiver_parallel_data_valid_synchronized,
    input  logic [DATA_WIDTH-1:0]                  receiver_parallel_data_synchronized,
    input  logic                                   register_file_read_data_valid,
    input  logic [DATA_WIDTH-1:0]                  register_file_read_data,
    input  logic                                   ALU_result_valid,
    input  logic [ALU_RESULT_WIDTH-1:0]            ALU_result,
    input  logic                                   transmitter_busy_synchronized,
    output logic                                   transmitter_parallel_data_valid,
    output logic [DATA_WIDTH-1:0]                  transmitter_parallel_data,
    output logic [$clog2(REGISTER_FILE_DEPTH)-1:0] register_file_address,
    output logic                                   register_file_write_enable,
    output logic [DATA_WIDTH-1:0]                  register_file_write_data,
    output logic                                   register_file_read_enable,
    output logic [3:0]                             ALU_function,
    output logic                                   ALU_enable,
    output logic                                   ALU_clk_enable,
    output logic                                   error_pulse,
    output logic                                   busy
);

    localparam int unsigned AW   = $clog2(REGISTER_FILE_DEPTH);
    localparam int unsigned NB   = ALU_RESULT_WIDTH / DATA_WIDTH;
    localparam int unsigned CW   = $clog2(NB + 1);
    localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CMPW = DATA_WIDTH + 1;

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUNC, REG_WRITE, REG_READ,
        WAIT_READ, WR_OPA, WR_OPB, ALU_EXEC, WAIT_ALU, TX_LOAD, TX_WAIT_HIGH, TX_WAIT_LOW
    } state_t;

    typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_ALU_OPS, OP_ALU} op_t;

    state_t                      state_q, state_n;
    op_t                         op_q, op_n;
    logic [AW-1:0]               addr_q, addr_n;
    logic [DATA_WIDTH-1:0]       opa_q, opa_n, opb_q, opb_n;
    logic [3:0]                  func_q, func_n;
    logic [ALU_RESULT_WIDTH-1:0] shift_q, shift_n;
    logic [CW-1:0]               left_q, left_n;
    logic [TW-1:0]               timer_q, timer_n;

    logic                  tx_valid_n, rf_we_n, rf_re_n, alu_en_n, alu_clk_n, err_n, busy_n;
    logic [DATA_WIDTH-1:0] tx_data_n, rf_wd_n;
    logic [AW-1:0]         rf_addr_n;
    logic [3:0]            alu_func_n;

    logic                  rx_valid, rx_take, timed_out, addr_bad;
    logic [DATA_WIDTH-1:0] rx_byte;

    assign rx_valid  = receiver_parallel_data_valid_synchronized;
    assign rx_byte   = receiver_parallel_data_synchronized;
    assign timed_out = (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign addr_bad  = ({1'b0, rx_byte} >= CMPW'(REGISTER_FILE_DEPTH));

    // Next-state, datapath and next-output logic
    always_comb begin
        state_n    = state_q;
        op_n       = op_q;
        addr_n     = addr_q;
        opa_n      = opa_q;
        opb_n      = opb_q;
        func_n     = func_q;
        shift_n    = shift_q;
        left_n     = left_q;
        tx_valid_n = 1'b0;
        tx_data_n  = transmitter_parallel_data;
        rf_addr_n  = register_file_address;
        rf_we_n    = 1'b0;
        rf_wd_n    = register_file_write_data;
        rf_re_n    = 1'b0;
        alu_func_n = ALU_function;
        alu_en_n   = 1'b0;
        alu_clk_n  = ALU_clk_enable;
        err_n      = 1'b0;
        rx_take    = rx_valid && (state_q inside {IDLE, GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUNC});

        case (state_q)
            IDLE: if (rx_valid) begin
                case (rx_byte[7:0])
                    8'hAA: begin op_n = OP_WRITE;   state_n = GET_ADDR; end
                    8'hBB: begin op_n = OP_READ;    state_n = GET_ADDR; end
                    8'hCC: begin op_n = OP_ALU_OPS; state_n = GET_OPA;  end
                    8'hDD: begin op_n = OP_ALU;     state_n = GET_FUNC; end
                    default: begin
                        shift_n = ALU_RESULT_WIDTH'(ERROR_CODE);
                        left_n  = CW'(1);
                        err_n   = 1'b1;
                        state_n = TX_LOAD;
                    end
                endcase
            end
            GET_ADDR: if (rx_valid) begin
                if (addr_bad) begin
                    shift_n = ALU_RESULT_WIDTH'(ERROR_CODE);
                    left_n  = CW'(1);
                    err_n   = 1'b1;
                    state_n = TX_LOAD;
                end else if (op_q == OP_READ) begin
                    rf_addr_n = rx_byte[AW-1:0];
                    rf_re_n   = 1'b1;
                    state_n   = REG_READ;
                end else begin
                    addr_n  = rx_byte[AW-1:0];
                    state_n = GET_DATA;
                end
            end else if (timed_out) begin
                err_n = 1'b1; state_n = IDLE;
            end
            GET_DATA: if (rx_valid) begin
                rf_addr_n = addr_q;
                rf_wd_n   = rx_byte;
                rf_we_n   = 1'b1;
                state_n   = REG_WRITE;
            end else if (timed_out) begin
                err_n = 1'b1; state_n = IDLE;
            end
            GET_OPA: if (rx_valid) begin
                opa_n = rx_byte; state_n = GET_OPB;
            end else if (timed_out) begin
                err_n = 1'b1; state_n = IDLE;
            end
            GET_OPB: if (rx_valid) begin
                opb_n = rx_byte; state_n = GET_FUNC;
            end else if (timed_out) begin
                err_n = 1'b1; state_n = IDLE;
            end
            GET_FUNC: if (rx_valid) begin
                func_n    = rx_byte[3:0];
                alu_clk_n = 1'b1;
                if (op_q == OP_ALU_OPS) begin
                    rf_addr_n = AW'(0);
                    rf_wd_n   = opa_q;
                    rf_we_n   = 1'b1;
                    state_n   = WR_OPA;
                end else begin
                    alu_func_n = rx_byte[3:0];
                    alu_en_n   = 1'b1;
                    state_n    = ALU_EXEC;
                end
            end else if (timed_out) begin
                err_n = 1'b1; state_n = IDLE;
            end
            REG_WRITE: state_n = IDLE;
            REG_READ, WAIT_READ: if (register_file_read_data_valid) begin
                shift_n = ALU_RESULT_WIDTH'(register_file_read_data);
                left_n  = CW'(1);
                state_n = TX_LOAD;
            end else if (state_q == REG_READ) begin
                state_n = WAIT_READ;
            end else if (timed_out) begin
                err_n = 1'b1; state_n = IDLE;
            end
            WR_OPA: begin
                rf_addr_n = AW'(1);
                rf_wd_n   = opb_q;
                rf_we_n   = 1'b1;
                state_n   = WR_OPB;
            end
            WR_OPB: begin
                alu_func_n = func_q;
                alu_en_n   = 1'b1;
                state_n    = ALU_EXEC;
            end
            ALU_EXEC, WAIT_ALU: if (ALU_result_valid) begin
                shift_n   = ALU_result;
                left_n    = CW'(NB);
                alu_clk_n = 1'b0;
                state_n   = TX_LOAD;
            end else if (state_q == ALU_EXEC) begin
                state_n = WAIT_ALU;
            end else if (timed_out) begin
                err_n = 1'b1; state_n = IDLE;
            end
            TX_LOAD: if (!transmitter_busy_synchronized) begin
                tx_valid_n = 1'b1;
                tx_data_n  = shift_q[DATA_WIDTH-1:0];
                state_n    = TX_WAIT_HIGH;
            end
            TX_WAIT_HIGH: if (transmitter_busy_synchronized) begin
                state_n = TX_WAIT_LOW;
            end else if (timed_out) begin
                err_n = 1'b1; state_n = IDLE;
            end
            TX_WAIT_LOW: if (!transmitter_busy_synchronized) begin
                if (left_q > CW'(1)) begin
                    left_n  = left_q - CW'(1);
                    shift_n = shift_q >> DATA_WIDTH;
                    state_n = TX_LOAD;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Leaving the ALU path any other way (timeout) must also gate its clock.
        if (state_n == IDLE) alu_clk_n = 1'b0;
        busy_n = (state_n != IDLE);

        if ((state_n != state_q) || rx_take) timer_n = '0;
        else if (!timed_out)                 timer_n = timer_q + TW'(1);
        else                                 timer_n = timer_q;
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q                         <= IDLE;
            op_q                            <= OP_WRITE;
            addr_q                          <= '0;
            opa_q                           <= '0;
            opb_q                           <= '0;
            func_q                          <= '0;
            shift_q                         <= '0;
            left_q                          <= '0;
            timer_q                         <= '0;
            transmitter_parallel_data_valid <= 1'b0;
            transmitter_parallel_data       <= '0;
            register_file_address           <= '0;
            register_file_write_enable      <= 1'b0;
            register_file_write_data        <= '0;
            register_file_read_enable       <= 1'b0;
            ALU_function                    <= '0;
            ALU_enable                      <= 1'b0;
            ALU_clk_enable                  <= 1'b0;
            error_pulse                     <= 1'b0;
            busy                            <= 1'b0;
        end else begin
            state_q                         <= state_n;
            op_q                            <= op_n;
            addr_q                          <= addr_n;
            opa_q                           <= opa_n;
            opb_q                           <= opb_n;
            func_q                          <= func_n;
            shift_q                         <= shift_n;
            left_q                          <= left_n;
            timer_q                         <= timer_n;
            transmitter_parallel_data_valid <= tx_valid_n;
            transmitter_parallel_data       <= tx_data_n;
            register_file_address           <= rf_addr_n;
            register_file_write_enable      <= rf_we_n;
            register_file_write_data        <= rf_wd_n;
            register_file_read_enable       <= rf_re_n;
            ALU_function                    <= alu_func_n;
            ALU_enable                      <= alu_en_n;
            ALU_clk_enable                  <= alu_clk_n;
            error_pulse                     <= err_n;
            busy                            <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_command_sequencer.sv
// Bench for uart_command_sequencer: directed frames then random frames, with
// register-file, ALU and UART-TX responders and a frame-level expectation model.
module tb_uart_command_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rf_rvalid = 1'b0;
    logic [7:0]  rf_rdata = '0;
    logic        alu_valid = 1'b0;
    logic [15:0] alu_res = '0;
    logic        tx_busy = 1'b0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [3:0]  rf_addr;
    logic        rf_we;
    logic [7:0]  rf_wd;
    logic        rf_re;
    logic [3:0]  alu_func;
    logic        alu_en;
    logic        alu_clk;
    logic        err;
    logic        busy;

    uart_command_sequencer dut (
        .clk                                       (clk),
        .reset                                     (reset),
        .receiver_parallel_data_valid_synchronized (rx_valid),
        .receiver_parallel_data_synchronized       (rx_data),
        .register_file_read_data_valid             (rf_rvalid),
        .register_file_read_data                   (rf_rdata),
        .ALU_result_valid                          (alu_valid),
        .ALU_result                                (alu_res),
        .transmitter_busy_synchronized             (tx_busy),
        .transmitter_parallel_data_valid           (tx_valid),
        .transmitter_parallel_data                 (tx_data),
        .register_file_address                     (rf_addr),
        .register_file_write_enable                (rf_we),
        .register_file_write_data                  (rf_wd),
        .register_file_read_enable                 (rf_re),
        .ALU_function                              (alu_func),
        .ALU_enable                                (alu_en),
        .ALU_clk_enable                            (alu_clk),
        .error_pulse                               (err),
        .busy                                      (busy)
    );

    typedef struct {int a; int d; int c;} ev_t;

    ev_t wr_q[$], rd_q[$], alu_q[$], tx_q[$];
    int  err_q[$];
    int  cyc = 0, clk_rise = -1, clk_fall = -1, busy_fall = -1, alu_valid_cyc = -1;
    logic clk_prev = 1'b0, busy_prev = 1'b0;
    int  checks = 0, errors = 0;

    logic [7:0]  env_mem [16];
    logic [7:0]  ref_mem [16];
    int          rd_delay = 2, alu_delay = 2, tx_len = 3;
    logic [15:0] alu_value = '0;
    int          rd_cnt = 0, alu_cnt = 0, tx_timer = 0, spacing_viol = 0;
    logic [7:0]  rd_pend = '0;
    logic        fall_seen = 1'b1, tx_busy_prev = 1'b0;

    // Event monitor: outputs sampled mid-cycle, cyc = index of the cycle being observed
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            if (rf_we)    wr_q.push_back('{int'(rf_addr), int'(rf_wd), cyc});
            if (rf_re)    rd_q.push_back('{int'(rf_addr), 0, cyc});
            if (alu_en)   alu_q.push_back('{int'(alu_func), 0, cyc});
            if (tx_valid) tx_q.push_back('{0, int'(tx_data), cyc});
            if (err)      err_q.push_back(cyc);
            if (alu_clk && !clk_prev) clk_rise = cyc;
            if (!alu_clk && clk_prev) clk_fall = cyc;
            if (!busy && busy_prev)   busy_fall = cyc;
        end
        clk_prev  = alu_clk;
        busy_prev = busy;
    end

    // Responders: register file, ALU and UART transmitter
    always @(negedge clk) begin
        #1;
        rf_rvalid = 1'b0;
        alu_valid = 1'b0;
        if (rd_cnt != 0) begin
            rd_cnt = rd_cnt - 1;
            if (rd_cnt == 0) begin rf_rvalid = 1'b1; rf_rdata = rd_pend; end
        end
        if (rf_re) begin rd_cnt = rd_delay; rd_pend = env_mem[rf_addr]; end
        if (rf_we) env_mem[rf_addr] = rf_wd;
        if (alu_cnt != 0) begin
            alu_cnt = alu_cnt - 1;
            if (alu_cnt == 0) begin alu_valid = 1'b1; alu_res = alu_value; alu_valid_cyc = cyc; end
        end
        if (alu_en) alu_cnt = alu_delay;
        if (tx_valid) begin
            if (!fall_seen) spacing_viol = spacing_viol + 1;
            fall_seen = 1'b0;
            tx_timer  = tx_len + 1;
        end else if (tx_timer != 0) begin
            tx_timer = tx_timer - 1;
        end
        tx_busy_prev = tx_busy;
        tx_busy = (tx_timer != 0) && (tx_timer <= tx_len);
        if (tx_busy_prev && !tx_busy) fall_seen = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic ev_t at(input ev_t q[$], input int i);
        if (i < q.size()) return q[i];
        return '{-1, -1, -1};
    endfunction

    function automatic int err_at(input int i);
        if (i < err_q.size()) return err_q[i];
        return -10000;
    endfunction

    task automatic clear_logs();
        wr_q.delete(); rd_q.delete(); alu_q.delete(); tx_q.delete(); err_q.delete();
    endtask

    task automatic send_frame(input logic [7:0] bytes[$], input int max_gap, output int n);
        n = -1;
        foreach (bytes[i]) begin
            if (i > 0 && max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
            @(negedge clk); #1;
            rx_valid = 1'b1;
            rx_data  = bytes[i];
            n        = cyc;
            @(negedge clk); #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int k = 0;
        repeat (3) @(negedge clk);
        while (busy === 1'b1 && k < limit) begin @(negedge clk); k++; end
        chk({tag, "_idle"}, busy, 0);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int n;
        logic [7:0] fr[$];
        foreach (env_mem[i]) begin env_mem[i] = '0; ref_mem[i] = '0; end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data",  tx_data,  0);
        chk("rst_rf_addr",  rf_addr,  0);
        chk("rst_rf_we",    rf_we,    0);
        chk("rst_rf_wd",    rf_wd,    0);
        chk("rst_rf_re",    rf_re,    0);
        chk("rst_alu_func", alu_func, 0);
        chk("rst_alu_en",   alu_en,   0);
        chk("rst_alu_clk",  alu_clk,  0);
        chk("rst_err",      err,      0);
        chk("rst_busy",     busy,     0);
        @(negedge clk); #1; reset = 1'b0;
        repeat (2) @(negedge clk);

        // Write AA 05 3C
        clear_logs();
        fr = '{8'hAA, 8'h05, 8'h3C};
        send_frame(fr, 0, n);
        wait_idle("aa", 50);
        ref_mem[5] = 8'h3C;
        chk("aa_wr_count", wr_q.size(), 1);
        chk("aa_wr_addr", at(wr_q, 0).a, 5);
        chk("aa_wr_data", at(wr_q, 0).d, 8'h3C);
        chk("aa_wr_cycle", at(wr_q, 0).c, n + 1);
        chk("aa_tx_count", tx_q.size(), 0);
        chk("aa_busy_low", busy_fall, n + 2);

        // Read BB 05 with two-cycle register latency
        clear_logs();
        rd_delay = 2;
        fr = '{8'hBB, 8'h05};
        send_frame(fr, 0, n);
        wait_idle("bb", 100);
        chk("bb_rd_count", rd_q.size(), 1);
        chk("bb_rd_addr", at(rd_q, 0).a, 5);
        chk("bb_rd_cycle", at(rd_q, 0).c, n + 1);
        chk("bb_tx_count", tx_q.size(), 1);
        chk("bb_tx_data", at(tx_q, 0).d, 8'h3C);
        chk("bb_tx_after_data", at(tx_q, 0).c > n + 3, 1);
        chk("bb_err_count", err_q.size(), 0);

        // ALU with operands CC 10 20 00, result 0x0030
        clear_logs();
        alu_value = 16'h0030; alu_delay = 2; tx_len = 3;
        fr = '{8'hCC, 8'h10, 8'h20, 8'h00};
        send_frame(fr, 0, n);
        wait_idle("cc", 100);
        ref_mem[0] = 8'h10; ref_mem[1] = 8'h20;
        chk("cc_wr_count", wr_q.size(), 2);
        chk("cc_wr0_addr", at(wr_q, 0).a, 0);
        chk("cc_wr0_data", at(wr_q, 0).d, 8'h10);
        chk("cc_wr0_cycle", at(wr_q, 0).c, n + 1);
        chk("cc_wr1_addr", at(wr_q, 1).a, 1);
        chk("cc_wr1_data", at(wr_q, 1).d, 8'h20);
        chk("cc_wr1_cycle", at(wr_q, 1).c, n + 2);
        chk("cc_alu_count", alu_q.size(), 1);
        chk("cc_alu_func", at(alu_q, 0).a, 0);
        chk("cc_alu_cycle", at(alu_q, 0).c, n + 3);
        chk("cc_clk_rise", clk_rise, n + 1);
        chk("cc_clk_fall", clk_fall, alu_valid_cyc + 1);
        chk("cc_tx_count", tx_q.size(), 2);
        chk("cc_tx0", at(tx_q, 0).d, 8'h30);
        chk("cc_tx1", at(tx_q, 1).d, 8'h00);
        chk("cc_spacing", spacing_viol, 0);

        // Unknown opcode 0x55
        clear_logs();
        fr = '{8'h55};
        send_frame(fr, 0, n);
        wait_idle("bad_op", 100);
        chk("bad_op_err_count", err_q.size(), 1);
        chk("bad_op_err_prompt", (err_at(0) - n) <= 1 && (err_at(0) >= n), 1);
        chk("bad_op_tx_count", tx_q.size(), 1);
        chk("bad_op_tx_data", at(tx_q, 0).d, 8'hEE);
        chk("bad_op_no_access", wr_q.size() + rd_q.size() + alu_q.size(), 0);

        // Out-of-range address AA 13
        clear_logs();
        fr = '{8'hAA, 8'h13};
        send_frame(fr, 0, n);
        wait_idle("bad_addr", 100);
        chk("bad_addr_err_count", err_q.size(), 1);
        chk("bad_addr_tx_count", tx_q.size(), 1);
        chk("bad_addr_tx_data", at(tx_q, 0).d, 8'hEE);
        chk("bad_addr_wr_count", wr_q.size(), 0);

        // Inter-byte timeout after AA 05
        clear_logs();
        fr = '{8'hAA, 8'h05};
        send_frame(fr, 0, n);
        wait_idle("tmo", 1300);
        chk("tmo_err_count", err_q.size(), 1);
        chk("tmo_err_delay", (err_at(0) - n >= 1024) && (err_at(0) - n <= 1026), 1);
        chk("tmo_tx_count", tx_q.size(), 0);
        chk("tmo_wr_count", wr_q.size(), 0);

        // Normal write after the timeout
        clear_logs();
        fr = '{8'hAA, 8'h06, 8'h77};
        send_frame(fr, 0, n);
        wait_idle("after_tmo", 50);
        ref_mem[6] = 8'h77;
        chk("after_tmo_wr_count", wr_q.size(), 1);
        chk("after_tmo_wr_addr", at(wr_q, 0).a, 6);
        chk("after_tmo_wr_data", at(wr_q, 0).d, 8'h77);
        chk("after_tmo_err_count", err_q.size(), 0);

        // Random frames against the frame-level model
        for (int f = 0; f < 40; f++) begin
            int kind, addr, gap, exp_rd, exp_alu, exp_err;
            logic [7:0] d, a, b, fn, op;
            ev_t exp_wr[$];
            int  exp_tx[$];
            string t;
            kind = $urandom_range(0, 4);
            addr = $urandom_range(0, 19);
            d = 8'($urandom); a = 8'($urandom); b = 8'($urandom); fn = 8'($urandom);
            alu_value = 16'($urandom);
            rd_delay  = $urandom_range(1, 4);
            alu_delay = $urandom_range(1, 4);
            tx_len    = $urandom_range(1, 5);
            gap = 3; exp_rd = -1; exp_alu = -1; exp_err = 0;
            exp_wr.delete(); exp_tx.delete(); fr.delete();
            case (kind)
                0: begin
                    fr = '{8'hAA, 8'(addr), d};
                    if (addr < 16) begin
                        exp_wr.push_back('{addr, int'(d), 0});
                        ref_mem[addr] = d;
                    end else begin
                        exp_err = 1; exp_tx.push_back(8'hEE); gap = 0;
                    end
                end
                1: begin
                    fr = '{8'hBB, 8'(addr)};
                    if (addr < 16) begin
                        exp_rd = addr; exp_tx.push_back(int'(ref_mem[addr]));
                    end else begin
                        exp_err = 1; exp_tx.push_back(8'hEE);
                    end
                end
                2: begin
                    fr = '{8'hCC, a, b, fn};
                    exp_wr.push_back('{0, int'(a), 0});
                    exp_wr.push_back('{1, int'(b), 0});
                    ref_mem[0] = a; ref_mem[1] = b;
                    exp_alu = fn % 16;
                    exp_tx.push_back(alu_value % 256);
                    exp_tx.push_back(alu_value / 256);
                end
                3: begin
                    fr = '{8'hDD, fn};
                    exp_alu = fn % 16;
                    exp_tx.push_back(alu_value % 256);
                    exp_tx.push_back(alu_value / 256);
                end
                default: begin
                    do op = 8'($urandom); while (op == 8'hAA || op == 8'hBB || op == 8'hCC || op == 8'hDD);
                    fr = '{op};
                    exp_err = 1; exp_tx.push_back(8'hEE);
                end
            endcase
            clear_logs();
            send_frame(fr, gap, n);
            t = $sformatf("r%0d_k%0d", f, kind);
            wait_idle(t, 200);
            chk({t, "_wr_count"}, wr_q.size(), exp_wr.size());
            foreach (exp_wr[i]) begin
                chk($sformatf("%s_wr%0d_addr", t, i), at(wr_q, i).a, exp_wr[i].a);
                chk($sformatf("%s_wr%0d_data", t, i), at(wr_q, i).d, exp_wr[i].d);
            end
            chk({t, "_rd_count"}, rd_q.size(), (exp_rd >= 0) ? 1 : 0);
            if (exp_rd >= 0) chk({t, "_rd_addr"}, at(rd_q, 0).a, exp_rd);
            chk({t, "_alu_count"}, alu_q.size(), (exp_alu >= 0) ? 1 : 0);
            if (exp_alu >= 0) chk({t, "_alu_func"}, at(alu_q, 0).a, exp_alu);
            chk({t, "_err_count"}, err_q.size(), exp_err);
            chk({t, "_tx_count"}, tx_q.size(), exp_tx.size());
            foreach (exp_tx[i]) chk($sformatf("%s_tx%0d", t, i), at(tx_q, i).d, exp_tx[i]);
        end

        chk("strobe_spacing_total", spacing_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_command_sequencer.md
# uart_command_sequencer

Parametrised successor to the system controller. It decodes multi-byte UART command frames into register-file and ALU operations, then serialises multi-byte responses back to the UART transmitter. Over the previous generation it adds:
- configurable ALU result width, with responses split into bytes automatically;
- address range checking;
- error/NACK responses;
- inter-byte and response timeouts.

It sits between the synchronised UART RX/TX domain crossings and the register file/ALU.

## Interface
Parameters:
- DATA_WIDTH, 8: UART byte and register width; must be ≥ 8.
- REGISTER_FILE_DEPTH, 16: number of register-file entries; AW = $clog2(REGISTER_FILE_DEPTH).
- ALU_RESULT_WIDTH, 16: ALU result width; must be a multiple of DATA_WIDTH. NB = ALU_RESULT_WIDTH/DATA_WIDTH.
- TIMEOUT_CYCLES, 1024: idle-cycle limit for frame bytes and for responses.
- ERROR_CODE, 8'hEE: byte transmitted on any error.

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- receiver_parallel_data_valid_synchronized  in  1  one-cycle strobe marking a received byte.
- receiver_parallel_data_synchronized  in  DATA_WIDTH  received byte.
- register_file_read_data_valid  in  1  read data strobe from the register file.
- register_file_read_data  in  DATA_WIDTH  register read data.
- ALU_result_valid  in  1  ALU result strobe.
- ALU_result  in  ALU_RESULT_WIDTH  ALU result.
- transmitter_busy_synchronized  in  1  UART TX busy.
- transmitter_parallel_data_valid  out  1  one-cycle strobe for a byte to transmit.
- transmitter_parallel_data  out  DATA_WIDTH  byte to transmit.
- register_file_address  out  AW  register-file address.
- register_file_write_enable  out  1  register write strobe.
- register_file_write_data  out  DATA_WIDTH  register write data.
- register_file_read_enable  out  1  register read strobe.
- ALU_function  out  4  ALU operation select.
- ALU_enable  out  1  ALU start strobe.
- ALU_clk_enable  out  1  ALU clock-gate enable.
- error_pulse  out  1  one-cycle pulse on any error.
- busy  out  1  high in every state other than IDLE.

## Operation
- Opcode is the low 8 bits of the first frame byte:
  - 0xAA write: ADDR, DATA.
  - 0xBB read: ADDR.
  - 0xCC ALU with operands: A, B, FUNC.
  - 0xDD ALU without operands: FUNC.
- FSM states: IDLE, GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUNC, REG_WRITE, REG_READ, WAIT_READ, WR_OPA, WR_OPB, ALU_EXEC, WAIT_ALU, TX_LOAD, TX_WAIT_HIGH, TX_WAIT_LOW.
- Operand bytes are captured into internal registers when received. FUNC uses its low 4 bits.
- Address check: an ADDR byte whose value is ≥ REGISTER_FILE_DEPTH is an error.
  - The FSM goes straight to TX_LOAD with ERROR_CODE and pulses error_pulse.
  - No register access occurs.
- Unknown opcode is handled the same way: error_pulse, ERROR_CODE transmitted, return to IDLE.
- 0xAA performs the register write; there is no response byte.
- 0xBB transmits the read byte.
- 0xCC writes A to address 0, then B to address 1, then starts the ALU. 0xDD starts the ALU directly.
- ALU results are transmitted as NB bytes, least-significant byte first, from a captured copy of the result.
- Transmit handshake, per byte:
  - In TX_LOAD, wait until transmitter_busy_synchronized is low.
  - Pulse transmitter_parallel_data_valid with the byte.
  - Wait for busy to go high (TX_WAIT_HIGH), then low (TX_WAIT_LOW).
  - Then send the next byte or return to IDLE.
- Received bytes that arrive in any state other than IDLE or the GET_* states are dropped silently.
- Timeout behaviour:
  - A counter resets on every accepted byte and on every state change.
  - If it reaches TIMEOUT_CYCLES in any GET_* state, WAIT_READ, WAIT_ALU or TX_WAIT_HIGH, the FSM returns to IDLE and pulses error_pulse.
  - Nothing is transmitted on a timeout.
- Reset mid-operation: the FSM returns to IDLE, any frame in progress is discarded, and any pending response bytes are discarded.

## Timing
- Reset values: every output is 0 (address, data and function outputs included); the FSM is in IDLE.
- Cycle numbering: cycle N is the cycle in which the final frame byte is sampled.
- 0xAA: register_file_write_enable is high for exactly cycle N+1, with address and data stable.
- 0xBB:
  - register_file_read_enable is high for cycle N+1 only.
  - The read data is captured on the register_file_read_data_valid cycle.
  - transmitter_parallel_data_valid pulses no earlier than the following cycle.
- 0xCC:
  - Write to address 0 at N+1, write to address 1 at N+2.
  - ALU_enable is high for N+3 only, with ALU_function valid that cycle.
- 0xDD: ALU_enable is high at N+1.
- ALU_clk_enable timing:
  - 0xCC: high from N+1.
  - 0xDD: high from N+1.
  - Both: stays high through the ALU_result_valid cycle, then deasserts the following cycle.
- Error response: transmitter_parallel_data_valid pulses at the earliest one cycle after the offending byte. error_pulse is high in the cycle the error is detected.
- transmitter_parallel_data is held stable from its valid strobe until the next strobe.
- Strobe spacing: no two transmitter_parallel_data_valid strobes are issued without an observed busy high→low between them.

## Test plan
- Frame AA 05 3C:
  - A single write with address 5 and data 0x3C at N+1.
  - No TX strobe.
  - busy returns low at N+2.
- Frame BB 05, register returns 0x3C after 2 cycles: read_enable is high at N+1 and exactly one TX byte 0x3C follows.
- Frame CC 10 20 00, ALU_RESULT_WIDTH=16, ALU returns 0x0030:
  - Writes are addr 0 = 0x10, then addr 1 = 0x20.
  - ALU_enable is high at N+3 with function 0.
  - TX bytes are 0x30 then 0x00.
  - The second strobe is issued only after busy high→low is modelled.
- Frame 0x55: error_pulse, one TX byte 0xEE, no register or ALU activity.
- Frame AA 13 (address 19 with depth 16): error, TX 0xEE, no write.
- Frame AA 05 followed by no further byte for 1024 cycles: error_pulse, return to IDLE, no TX.
- A following AA 06 77 then executes normally.
